bids22_round_sched: RTL and testbench

Round scheduler and configuration sequencer for the bids22 auction core. It buffers host control commands in a small FIFO and replays them onto the core's `C_op`/`C_data` port one at a time, gated by `ready`. On request it starts a bidding round by holding `C_start`, waits for `roundOver`, and captures the winner and `maxBid`. It sits between the host/testbench control path and the auction core's controller-side ports.

---
 rtl/bids22_sched_pkg.sv | 41 ++++
 rtl/bids22_round_sched_fifo.sv | 49 ++++
 rtl/bids22_round_sched.sv | 147 ++++++++++++++
 tb/tb_bids22_round_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bids22_sched_pkg.sv
// Shared types for the bids22 round scheduler.
// Opcodes, FSM states, winner codes and command bundle.
package bids22_sched_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    START,
    ROUND
  } sched_state_e;

  typedef enum logic [1:0] {
    NONE,
    WX,
    WY,
    WZ
  } winner_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] data;
  } cmd_t;

  // f = {x, y, z}; anything but a single flag encodes as NONE
  function automatic winner_e win_enc(input logic [2:0] f);
    case (f)
      3'b100:  return WX;
      3'b010:  return WY;
      3'b001:  return WZ;
      default: return NONE;
    endcase
  endfunction

  function automatic logic win_multi(input logic [2:0] f);
    return (f[2] & f[1]) | (f[2] & f[0]) | (f[1] & f[0]);
  endfunction

endpackage

// File: rtl/bids22_round_sched_fifo.sv
// Command FIFO for the bids22 round scheduler.
// Power-of-two depth, wrapping pointers, full/empty/count.
module bids22_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/bids22_round_sched.sv
// Round scheduler: replays buffered host ops to the core,
// then runs a bidding round and captures the winner.
module bids22_round_sched
  import bids22_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        start_req,
  output logic [3:0]  C_op,
  output logic [31:0] C_data,
  output logic        C_start,
  input  logic        ready,
  input  logic [2:0]  err,
  input  logic        roundOver,
  input  logic        X_win,
  input  logic        Y_win,
  input  logic        Z_win,
  input  logic [31:0] maxBid,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [31:0] win_amt,
  output logic        ctrl_err,
  output logic [2:0]  last_err,
  output logic [7:0]  round_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  sched_state_e st, nxt;
  cmd_t         wr_cmd, rd_cmd;
  logic         full, empty, pop;
  logic [CW-1:0] fcnt;
  logic [TW-1:0] timer;
  logic         start_pend;
  logic         tmo;
  logic [2:0]   flags;
  winner_e      win_q;

  assign wr_cmd    = '{op: cmd_op, data: cmd_data};
  assign cmd_ready = !full;
  assign busy      = (st != IDLE) || (fcnt != '0);
  assign tmo       = (timer == TMAX);
  assign flags     = {X_win, Y_win, Z_win};
  assign winner    = win_q;

  bids22_cmd_fifo #(
    .DEPTH(DEPTH),
    .W    ($bits(cmd_t))
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (cmd_valid),
    .wdata  (wr_cmd),
    .pop    (pop),
    .rdata  (rd_cmd),
    .full   (full),
    .empty  (empty),
    .count  (fcnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= nxt;
  end

  // Queued commands always win over a pending round
  always_comb begin
    nxt = st;
    pop = 1'b0;
    unique case (st)
      IDLE: begin
        if (!empty && ready) begin
          pop = 1'b1;
          nxt = ISSUE;
        end else if (empty && start_pend) begin
          nxt = START;
        end
      end
      ISSUE:   nxt = CHECK;
      CHECK:   nxt = IDLE;
      START:   nxt = ROUND;
      ROUND:   if (roundOver || tmo) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      C_op       <= OP_NOP;
      C_data     <= '0;
      C_start    <= 1'b0;
      done       <= 1'b0;
      win_q      <= NONE;
      win_amt    <= '0;
      ctrl_err   <= 1'b0;
      last_err   <= '0;
      round_cnt  <= '0;
      timer      <= '0;
      start_pend <= 1'b0;
    end else begin
      C_op   <= OP_NOP;
      C_data <= '0;
      done   <= 1'b0;
      if (pop) begin
        C_op   <= rd_cmd.op;
        C_data <= rd_cmd.data;
      end
      if (st == CHECK) begin
        last_err <= err;
        if (err != '0) ctrl_err <= 1'b1;
      end
      if (st == START) begin
        C_start <= 1'b1;
        timer   <= '0;
      end
      if (st == ROUND) begin
        if (roundOver) begin
          C_start   <= 1'b0;
          done      <= 1'b1;
          win_q     <= win_enc(flags);
          win_amt   <= maxBid;
          round_cnt <= round_cnt + 8'd1;
          if (win_multi(flags)) ctrl_err <= 1'b1;
        end else if (tmo) begin
          C_start  <= 1'b0;
          ctrl_err <= 1'b1;
          win_q    <= NONE;
        end else begin
          timer <= timer + TW'(1);
        end
      end
      if (st == ROUND && (roundOver || tmo)) start_pend <= 1'b0;
      if (start_req) start_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bids22_round_sched.sv
// Randomised bench for bids22_round_sched with a
// transaction-level scoreboard for ops and rounds.
module tb_bids22_round_sched;

  localparam int TO = 64;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] data;
  } cmd_s;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready;
  logic        start_req = 1'b0;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ready = 1'b1;
  logic [2:0]  err = '0;
  logic        roundOver = 1'b0;
  logic        X_win = 1'b0;
  logic        Y_win = 1'b0;
  logic        Z_win = 1'b0;
  logic [31:0] maxBid = '0;
  logic        busy;
  logic        done;
  logic [1:0]  winner;
  logic [31:0] win_amt;
  logic        ctrl_err;
  logic [2:0]  last_err;
  logic [7:0]  round_cnt;

  int n_chk = 0;
  int n_pass = 0;

  cmd_s       exp_q[$];
  int         cyc = 0;
  int         last_cyc = -10;
  int         n_issued = 0;
  int         ph = 0;
  logic [2:0] exp_last = '0;
  logic       ectl_op = 1'b0;
  logic       ectl_rnd = 1'b0;
  logic       prev_rdy = 1'b0;

  bids22_round_sched #(
    .DEPTH  (4),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .start_req(start_req),
    .C_op     (C_op),
    .C_data   (C_data),
    .C_start  (C_start),
    .ready    (ready),
    .err      (err),
    .roundOver(roundOver),
    .X_win    (X_win),
    .Y_win    (Y_win),
    .Z_win    (Z_win),
    .maxBid   (maxBid),
    .busy     (busy),
    .done     (done),
    .winner   (winner),
    .win_amt  (win_amt),
    .ctrl_err (ctrl_err),
    .last_err (last_err),
    .round_cnt(round_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted commands must reappear once, in order,
  // with err sampled in the cycle after the op is shown.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      ph       = 0;
      exp_last = '0;
      ectl_op  = 1'b0;
      last_cyc = -10;
    end else begin
      cyc++;
      if (ph == 2) begin
        chk("last_err", 32'(last_err), 32'(exp_last));
        chk("ctrl_err_op", 32'(ctrl_err), 32'(ectl_op | ectl_rnd));
        ph = 0;
      end
      if (ph == 1) begin
        exp_last = err;
        if (err != 3'd0) ectl_op = 1'b1;
        ph = 2;
      end
      if (C_op != 4'h0) begin
        cmd_s c;
        n_issued++;
        chk("op_ready", 32'(prev_rdy), 32'd1);
        chk("op_gap", 32'(cyc - last_cyc >= 3), 32'd1);
        chk("op_in_round", 32'(C_start), 32'd0);
        if (exp_q.size() == 0) begin
          chk("op_unexp", 32'(C_op), 32'd0);
        end else begin
          c = exp_q.pop_front();
          chk("op", 32'(C_op), 32'(c.op));
          chk("data", C_data, c.data);
        end
        last_cyc = cyc;
        ph = 1;
      end
      if (cmd_valid && cmd_ready) exp_q.push_back('{cmd_op, cmd_data});
      prev_rdy = ready;
    end
  end

  task automatic do_reset();
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    start_req = 1'b0;
    roundOver = 1'b0;
    {X_win, Y_win, Z_win} = 3'b000;
    err       = '0;
    ready     = 1'b1;
    maxBid    = '0;
    ectl_rnd  = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !busy && ph == 0) break;
      step();
    end
    chk("drain_q", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int base;
    int hi;
    int dn;
    int rc;
    logic [2:0]  f;
    logic [31:0] amt;
    logic [1:0]  ew;

    do_reset();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_C_op", 32'(C_op), 32'd0);
    chk("rst_C_data", C_data, 32'd0);
    chk("rst_C_start", 32'(C_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_win_amt", win_amt, 32'd0);
    chk("rst_ctrl_err", 32'(ctrl_err), 32'd0);
    chk("rst_last_err", 32'(last_err), 32'd0);
    chk("rst_round_cnt", 32'(round_cnt), 32'd0);

    // single command latency
    push(4'h3, 32'h0000_1234);
    chk("lat_n1_op", 32'(C_op), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    step();
    chk("lat_n2_op", 32'(C_op), 32'd3);
    chk("lat_n2_data", C_data, 32'h1234);
    step();
    chk("lat_n3_op", 32'(C_op), 32'd0);
    step();
    step();
    chk("lat_last_err", 32'(last_err), 32'd0);
    chk("lat_ctrl_err", 32'(ctrl_err), 32'd0);
    drain();

    // fill with ready low: 5th command must be refused
    ready = 1'b0;
    step();
    base = n_issued;
    for (int i = 0; i < 5; i++) begin
      chk("full_cmd_ready", 32'(cmd_ready), 32'(i < 4));
      push(4'(i + 1), 32'hA000_0000 + 32'(i));
      cmd_valid = 1'b0;
    end
    repeat (10) step();
    chk("stall_no_ops", 32'(n_issued - base), 32'd0);
    drain();
    chk("full_nops", 32'(n_issued - base), 32'd4);

    // rounds, with commands buffered during ROUND
    rc = 0;
    for (int r = 0; r < 6; r++) begin
      start_req = 1'b1;
      step();
      start_req = 1'b0;
      chk("rs_n1", 32'(C_start), 32'd0);
      step();
      chk("rs_n2", 32'(C_start), 32'd0);
      step();
      chk("rs_cstart", 32'(C_start), 32'd1);
      for (int k = 0; k < r % 3; k++)
        push(4'($urandom_range(1, 15)), $urandom);
      repeat ($urandom_range(1, 6)) step();
      chk("rs_done_low", 32'(done), 32'd0);
      chk("rs_busy", 32'(busy), 32'd1);
      if (r == 0) begin
        f = 3'b010;
        amt = 32'd500;
      end else begin
        f = 3'($urandom_range(0, 7));
        amt = $urandom;
      end
      {X_win, Y_win, Z_win} = f;
      maxBid = amt;
      roundOver = 1'b1;
      step();
      roundOver = 1'b0;
      {X_win, Y_win, Z_win} = 3'b000;
      rc++;
      case ($countones(f))
        1:       ew = f[2] ? 2'd1 : (f[1] ? 2'd2 : 2'd3);
        default: ew = 2'd0;
      endcase
      if ($countones(f) > 1) ectl_rnd = 1'b1;
      chk("re_cstart", 32'(C_start), 32'd0);
      chk("re_done", 32'(done), 32'd1);
      chk("re_winner", 32'(winner), 32'(ew));
      chk("re_win_amt", win_amt, amt);
      chk("re_round_cnt", 32'(round_cnt), 32'(rc));
      chk("re_ctrl_err", 32'(ctrl_err), 32'(ectl_rnd));
      step();
      chk("re_done_pulse", 32'(done), 32'd0);
      drain();
    end

    // error from the core stays sticky
    do_reset();
    err = 3'b010;
    push(4'h5, 32'h55);
    drain();
    chk("err_last", 32'(last_err), 32'd2);
    chk("err_ctrl", 32'(ctrl_err), 32'd1);
    err = 3'b000;
    push(4'h6, 32'h66);
    push(4'h7, 32'h77);
    drain();
    chk("err_last_clean", 32'(last_err), 32'd0);
    chk("err_ctrl_sticky", 32'(ctrl_err), 32'd1);

    // randomised traffic with random ready and err
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = 4'($urandom_range(1, 15));
      cmd_data  = $urandom;
      ready     = ($urandom_range(0, 3) != 0);
      err       = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd0;
      step();
    end
    cmd_valid = 1'b0;
    err = 3'd0;
    drain();

    // timeout, with two requests collapsing into one round
    do_reset();
    start_req = 1'b1;
    step();
    step();
    start_req = 1'b0;
    for (int i = 0; i < 6 && !C_start; i++) step();
    hi = 0;
    dn = 0;
    while (C_start && hi < TO + 10) begin
      hi++;
      if (done) dn++;
      step();
    end
    chk("to_cycles", 32'(hi), 32'(TO));
    chk("to_cstart", 32'(C_start), 32'd0);
    chk("to_no_done", 32'(dn + int'(done)), 32'd0);
    chk("to_ctrl_err", 32'(ctrl_err), 32'd1);
    chk("to_round_cnt", 32'(round_cnt), 32'd0);
    chk("to_winner", 32'(winner), 32'd0);
    repeat (6) step();
    chk("to_collapse", 32'(C_start), 32'd0);

    // reset in the middle of a round with queued commands
    do_reset();
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    repeat (3) step();
    push(4'h9, 32'h99);
    push(4'hA, 32'hAA);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("mr_cstart", 32'(C_start), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    step();
    reset_n = 1'b1;
    base = n_issued;
    repeat (20) step();
    chk("mr_no_ops", 32'(n_issued - base), 32'd0);
    chk("mr_round_cnt", 32'(round_cnt), 32'd0);
    chk("mr_idle", 32'(C_start), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
